muldiv_seq: RTL



---
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the core, the register file ports and the
// iterative multiply/divide unit.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [4:0]      rd;
  logic            we;
  logic [XLEN-1:0] wdata;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, rd, we, wdata
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, rd, we, wdata
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: one bit per cycle on operand magnitudes,
// sign fix-up at the end, single-cycle register-file write on completion.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for start; operands latched on acceptance
  // CALC  | 32 shift-add / restoring shift-subtract iterations
  // FIX   | sign correction, special cases, result select
  // DONE  | result handed to the write-port registers
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [2:0]      op_q;
  logic [XLEN-1:0] dividend_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [4:0]      cnt_q;
  logic [4:0]      rd_q;
  logic            neg_q;
  logic            rem_neg_q;
  logic            b_zero_q;
  logic [XLEN-1:0] res_q;
  logic            done_q;
  logic            we_q;
  logic [4:0]      rd_out_q;
  logic [XLEN-1:0] wdata_q;

  logic            signed_a, signed_b, a_neg, b_neg, is_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0] quo_c, rem_c, fix_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // done_q high means the write-port cycle is still on the bus, so a new
  // request is not taken until the following cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.start && !done_q) begin
        accept  = 1'b1;
        state_d = CALC;
      end
      CALC: if (cnt_q == 5'd0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_div   = bus.funct3[2];
    signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
               (bus.funct3 == 3'b110);
    a_neg    = signed_a && bus.rs1_val[XLEN-1];
    b_neg    = signed_b && bus.rs2_val[XLEN-1];
    a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
    b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_c  = neg_q ? -prod : prod;
    quo_c   = neg_q ? -lo_q : lo_q;
    rem_c   = rem_neg_q ? -hi_q : hi_q;
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = b_zero_q ? '1 : quo_c;
      default:                fix_res = b_zero_q ? dividend_q : rem_c;
    endcase
  end

  // Multiply: lo holds the multiplier and collects product low bits as the
  // partial sum shifts right. Divide: lo holds the dividend and collects
  // quotient bits while hi is the running remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      dividend_q <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      b_zero_q   <= 1'b0;
      res_q      <= '0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      rd_out_q   <= '0;
      wdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      if (accept) begin
        op_q       <= bus.funct3;
        dividend_q <= bus.rs1_val;
        rd_q       <= bus.rd_in;
        neg_q      <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        b_zero_q   <= (bus.rs2_val == '0);
        hi_q       <= '0;
        lo_q       <= is_div ? a_mag : b_mag;
        opnd_q     <= is_div ? b_mag : a_mag;
        cnt_q      <= 5'd31;
      end
      if (state_q == CALC) begin
        cnt_q <= cnt_q - 5'd1;
        if (op_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_q <= div_diff[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_q <= div_shift[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_q <= mul_sum[XLEN:1];
          lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
      if (state_q == FIX) res_q <= fix_res;
      if (state_q == DONE) begin
        done_q   <= 1'b1;
        we_q     <= (rd_q != 5'd0);
        rd_out_q <= rd_q;
        wdata_q  <= res_q;
      end
    end
  end

  assign bus.busy  = (state_q != IDLE) || done_q;
  assign bus.done  = done_q;
  assign bus.we    = we_q;
  assign bus.rd    = rd_out_q;
  assign bus.wdata = wdata_q;

endmodule
